io_space_responder: RTL and testbench
=====================================

Name: io_space_responder

Overview:
- Memory-mapped I/O slave answering processor accesses whose address has adr[15:14] = 2'b11. This is the region where the memory enable is held low.
- Sits beside the exmem block on the same memread/memwrite/adr/writedata bus and returns read data on a separate iodata bus.
- Provides four registers:
  - an output FIFO drained by an external consumer through a valid/ready handshake;
  - a status register;
  - a down-counting timer;
  - a synchronized input port.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- OUT_W, 8, width of each FIFO entry and of out_data.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset.
- memread  in  1  processor read strobe.
- memwrite  in  1  processor write strobe.
- adr  in  16  processor address.
- writedata  in  16  processor write data.
- iodata  out  16  registered read data.
- out_data  out  OUT_W  head of the output FIFO.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- in_data  in  16  asynchronous external input (switches/buttons).

Behaviour:
- Select: sel = (adr[15:14] == 2'b11). The register index is adr[1:0]; adr[13:2] is ignored, so the register set aliases across the whole space. Accesses with sel=0 have no effect and iodata holds its value.
- Reset: a rising edge with rst=0 produces the following state:
  - FIFO emptied; out_valid=0; out_data=0;
  - iodata=0;
  - timer=0;
  - expired=0;
  - overflow=0;
  - both input synchronizer stages = 0.
- Register map:
  - 0: OUT. Write pushes writedata[OUT_W-1:0]. Read returns 0.
  - 1: STATUS (read only). Bit layout:
    - [0] empty
    - [1] full
    - [2] expired
    - [3] overflow
    - [7:4] count, zero-extended
    - [15:8] = 0
  - 2: TIMER. Write loads writedata. Read returns the current value.
  - 3: IN (read only). Returns in_data after a 2-flop synchronizer.
- Read latency: if memread & sel at edge N, iodata carries the register value at edge N+1. The value is sampled before any same-edge update. iodata holds until the next selected read.
- Simultaneous memread and memwrite: the write takes effect. iodata still captures the pre-write value.
- Writes to read-only registers are ignored.
- FIFO:
  - push = memwrite & sel & adr[1:0]==0;
  - pop = out_valid & out_ready;
  - count range 0..DEPTH; pointers wrap modulo DEPTH.
  - out_data is the head entry and is valid whenever out_valid=1. It holds stable until popped.
- FIFO boundary cases:
  - Push while full with no pop: data dropped, overflow set (sticky).
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only. out_valid rises on the next edge.
  - Pop while empty: impossible, because out_valid=0.
- Timer:
  - When nonzero and not being written, it decrements by 1 each cycle.
  - The transition 1 -> 0 sets expired (sticky).
  - A write of 0 stops the timer without setting expired.
  - A write on the same edge as a decrement: the write wins.
- Clear-on-read: a selected read of STATUS clears expired and overflow on that edge. If expiry or overflow occurs on the same edge as the clearing read, the set wins. The read data shows the pre-clear values.
- Reset mid-operation discards FIFO contents and stops the timer. The consumer must treat out_valid falling as abandonment.

Optional Feature:
- Macro: IO_SPACE_IRQ_EN.
- When defined:
  - An extra output port irq (1 bit) is added.
  - irq = expired | overflow | (empty & drain_ie). It is registered and is 0 at reset.
  - drain_ie is STATUS bit 8, writable by a write to index 1 (writedata[8]); all other STATUS bits remain read-only.
- When undefined:
  - No irq port.
  - STATUS[8] reads 0 and writes to index 1 are ignored.

Test Plan:
1. Reset with rst=0 for 2 cycles, then rst=1, then read adr=16'hC001. Required: iodata=16'h0001 one cycle later; out_valid=0.
2. With out_ready=0, write 16'h00A1, 00A2, 00A3, 00A4, 00A5 to 16'hC000 (DEPTH=4). Required:
   - STATUS = 16'h004A (count=4, full, overflow);
   - then out_ready=1 yields out_data A1, A2, A3, A4 on consecutive cycles;
   - out_valid falls after A4.
3. Write 16'h0003 to 16'hC002 and idle. Required:
   - reads of index 2 show 2, 1, 0;
   - STATUS bit 2 = 1;
   - a second STATUS read returns bit 2 = 0.
4. Hold in_data=16'h5A5A and read 16'hC003 two cycles after the change. Required: iodata=16'h5A5A. Also read 16'hFFF3 (alias). Required: same value.
5. Write 16'h1234 to adr=16'h8000 and 16'h0000, plus a memread at 16'h4001. Required: FIFO, timer and iodata unchanged.
6. Fill the FIFO to 4, then push and pop on the same edge. Required: count stays 4, overflow stays 0, and the new entry appears as the last output.

Source files
------------

// File: rtl/io_space_responder.sv
// rtl/io_space_responder.sv - I/O-space slave: output FIFO, status, down timer, synced input; optional irq under IO_SPACE_IRQ_EN
module io_space_responder #(
  parameter int DEPTH = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [15:0]      adr,
  input  logic [15:0]      writedata,
  output logic [15:0]      iodata,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [15:0]      in_data
`ifdef IO_SPACE_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] IDX_OUT    = 2'd0;
  localparam logic [1:0] IDX_STATUS = 2'd1;
  localparam logic [1:0] IDX_TIMER  = 2'd2;
  localparam logic [1:0] IDX_IN     = 2'd3;

  logic             sel;
  logic [1:0]       idx;
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [15:0]      timer;
  logic             expired;
  logic             overflow;
  logic [15:0]      sync1;
  logic [15:0]      sync2;
  logic             drain_ie;
  logic             empty;
  logic             full;
  logic             push_req;
  logic             pop;
  logic             push;
  logic             ovf_set;
  logic             exp_set;
  logic             timer_wr;
  logic             status_rd;
  logic [15:0]      status;
  logic [15:0]      rd_mux;
  logic             unused_adr;

  // Middle address bits are don't-care: the four registers alias across the region.
  assign unused_adr = ^adr[13:2];

  assign sel       = (adr[15:14] == 2'b11);
  assign idx       = adr[1:0];
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign out_valid = !empty;
  // Gate the head so out_data reads 0 whenever nothing is queued (including after reset).
  assign out_data  = empty ? '0 : mem[rd_ptr];

  assign push_req  = memwrite & sel & (idx == IDX_OUT);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push      = push_req & (!full | pop);
  assign ovf_set   = push_req & full & !pop;

  assign timer_wr  = memwrite & sel & (idx == IDX_TIMER);
  assign exp_set   = !timer_wr & (timer == 16'd1);
  assign status_rd = memread & sel & (idx == IDX_STATUS);

  assign status = {7'd0, drain_ie, 4'(count), overflow, expired, full, empty};

  // Read mux of pre-update register values.
  always_comb begin
    rd_mux = 16'd0;
    case (idx)
      IDX_OUT:    rd_mux = 16'd0;
      IDX_STATUS: rd_mux = status;
      IDX_TIMER:  rd_mux = timer;
      IDX_IN:     rd_mux = sync2;
      default:    rd_mux = 16'd0;
    endcase
  end

  // FIFO storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= writedata[OUT_W-1:0];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Down-counting timer; a processor write overrides the decrement.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timer <= 16'd0;
    end else if (timer_wr) begin
      timer <= writedata;
    end else if (timer != 16'd0) begin
      timer <= timer - 16'd1;
    end
  end

  // Sticky flags cleared by a STATUS read; a new event on the same edge wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      expired  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      expired  <= exp_set | (expired & !status_rd);
      overflow <= ovf_set | (overflow & !status_rd);
    end
  end

  // Registered read data, held until the next selected read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      iodata <= 16'd0;
    end else if (memread & sel) begin
      iodata <= rd_mux;
    end
  end

  // Two-flop synchronizer for the asynchronous input port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 16'd0;
      sync2 <= 16'd0;
    end else begin
      sync1 <= in_data;
      sync2 <= sync1;
    end
  end

`ifdef IO_SPACE_IRQ_EN
  // Drain interrupt enable lives in STATUS bit 8, the only writable STATUS bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drain_ie <= 1'b0;
    end else if (memwrite & sel & (idx == IDX_STATUS)) begin
      drain_ie <= writedata[8];
    end
  end

  // Registered interrupt request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq <= 1'b0;
    end else begin
      irq <= expired | overflow | (empty & drain_ie);
    end
  end
`else
  assign drain_ie = 1'b0;
`endif

endmodule

// File: tb/tb_io_space_responder.sv
// tb/tb_io_space_responder.sv - scoreboard bench for io_space_responder
module tb_io_space_responder;

  localparam int DEPTH = 4;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        memread   = 1'b0;
  logic        memwrite  = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] adr       = 16'd0;
  logic [15:0] writedata = 16'd0;
  logic [15:0] in_data   = 16'd0;
  logic [15:0] iodata;
  logic [7:0]  out_data;
  logic        out_valid;
`ifdef IO_SPACE_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] rd_q[$];
  string       tag_q[$];
  logic [7:0]  out_q[$];
  int          mcount  = 0;
  logic        mon_en  = 1'b0;
  logic        rd_pend = 1'b0;
  logic        m_pop;
  logic        m_push;
  logic        m_acc;

  always #5 clk = ~clk;

  io_space_responder #(.DEPTH(DEPTH), .OUT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .iodata    (iodata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_data   (in_data)
`ifdef IO_SPACE_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model of the output FIFO, advanced on each rising edge.
  assign m_pop  = (mcount != 0) && out_ready;
  assign m_push = memwrite && (adr[15:14] == 2'b11) && (adr[1:0] == 2'b00);
  assign m_acc  = m_push && ((mcount < DEPTH) || m_pop);

  always @(posedge clk) begin
    if (!rst) begin
      mcount <= 0;
      out_q.delete();
    end else begin
      if (m_pop) void'(out_q.pop_front());
      if (m_acc) out_q.push_back(writedata[7:0]);
      mcount <= mcount + (m_acc ? 1 : 0) - (m_pop ? 1 : 0);
    end
  end

  // Monitor on the falling edge: stream handshake and read-data scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", 16'(out_valid), 16'(mcount != 0));
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) check("out_q_underrun", 16'd1, 16'd0);
        else check("out_data", 16'(out_data), 16'(out_q[0]));
      end
      if (rd_pend) begin
        if (rd_q.size() == 0) check("rd_q_underrun", 16'd1, 16'd0);
        else check(tag_q.pop_front(), iodata, rd_q.pop_front());
      end
      rd_pend <= memread && (adr[15:14] == 2'b11);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    adr = a; writedata = d; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    adr = a; memread = 1'b1;
    rd_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    memread = 1'b0;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) tick();
    check("drain_done", 16'(out_valid), 16'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    rst = 1'b0;
    tick(); tick();
    check("rst_iodata", iodata, 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_data", 16'(out_data), 16'd0);
    rst = 1'b1;
    mon_en = 1'b1;
    rd("t1_status", 16'hC001, 16'h0001);
    tick();

    // 2: fill past full, overflow, then drain in order
    for (int i = 1; i <= 5; i++) wr(16'hC000, 16'h00A0 + 16'(i));
    rd("t2_status_full", 16'hC001, 16'h004A);
    drain();
    rd("t2_status_clr", 16'hC001, 16'h0001);

    // 3: timer countdown and sticky expiry cleared on read
    wr(16'hC002, 16'h0003);
    tick();
    rd("t3_timer2", 16'hC002, 16'h0002);
    rd("t3_timer1", 16'hC002, 16'h0001);
    rd("t3_timer0", 16'hC002, 16'h0000);
    rd("t3_status_exp", 16'hC001, 16'h0005);
    rd("t3_status_clr", 16'hC001, 16'h0001);

    // 4: synchronized input and aliasing
    in_data = 16'h5A5A;
    tick(); tick();
    rd("t4_in", 16'hC003, 16'h5A5A);
    rd("t4_in_alias", 16'hFFF3, 16'h5A5A);
    tick();

    // 5: unselected accesses have no effect
    wr(16'h8000, 16'h1234);
    wr(16'h0000, 16'h1234);
    adr = 16'h4001; memread = 1'b1;
    tick();
    memread = 1'b0;
    tick();
    check("t5_io_hold", iodata, 16'h5A5A);
    rd("t5_timer", 16'hC002, 16'h0000);
    rd("t5_status", 16'hC001, 16'h0001);

    // 6: push and pop on the same edge while full
    for (int i = 1; i <= 4; i++) wr(16'hC000, 16'h00B0 + 16'(i));
    adr = 16'hC000; writedata = 16'h00B5; memwrite = 1'b1; out_ready = 1'b1;
    tick();
    memwrite = 1'b0; out_ready = 1'b0;
    rd("t6_status_full", 16'hC001, 16'h0042);
    drain();
    rd("t6_status_empty", 16'hC001, 16'h0001);

    // 7: simultaneous read/write returns pre-write value; write of 0 stops without expiry
    adr = 16'hC002; writedata = 16'h0005; memread = 1'b1; memwrite = 1'b1;
    rd_q.push_back(16'h0000);
    tag_q.push_back("t7_rw_prev");
    tick();
    memread = 1'b0; memwrite = 1'b0;
    rd("t7_timer5", 16'hC002, 16'h0005);
    wr(16'hC002, 16'h0000);
    tick();
    rd("t7_timer_stop", 16'hC002, 16'h0000);
    rd("t7_status", 16'hC001, 16'h0001);

    tick(); tick(); tick();
    check("rd_q_left", 16'(rd_q.size()), 16'd0);
    check("out_q_left", 16'(out_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
